prmgmt_csr_master: RTL and testbench

//  Initiator side of the HSSI PR management bus. Converts single MAC CSR requests
//  (port, address, read/write) into the indirect E2E register sequence:

---
 rtl/prmgmt_csr_master_if.sv | 59 +++++
 rtl/prmgmt_csr_master.sv | 190 +++++++++++++++++++
 tb/tb_prmgmt_csr_master.sv | 304 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/prmgmt_csr_master_if.sv
// ---------------------------------------------------------------------------
// prmgmt_csr_master_if
// Bundles the request/response handshake of the CSR master with its PR
// management register-file bus.
//   req_*        : host request (valid/ready handshake)
//   rsp_*        : one-cycle completion pulse plus read data
//   prmgmt_cmd   : bit0 write strobe, bit1 read
//   prmgmt_addr  : E2E register index
//   prmgmt_din   : write data to the register file
//   prmgmt_dout  : registered read data from the register file
// Modports: master = the CSR master block, slave = host + register file side.
// ---------------------------------------------------------------------------
interface prmgmt_csr_master_if;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_port;
    logic [15:0] req_addr;
    logic [31:0] req_wdata;
    logic        rsp_valid;
    logic        rsp_write;
    logic [31:0] rsp_rdata;
    logic [15:0] prmgmt_cmd;
    logic [15:0] prmgmt_addr;
    logic [31:0] prmgmt_din;
    logic [31:0] prmgmt_dout;

    modport master (
        input  req_valid,
        input  req_write,
        input  req_port,
        input  req_addr,
        input  req_wdata,
        input  prmgmt_dout,
        output req_ready,
        output rsp_valid,
        output rsp_write,
        output rsp_rdata,
        output prmgmt_cmd,
        output prmgmt_addr,
        output prmgmt_din
    );

    modport slave (
        output req_valid,
        output req_write,
        output req_port,
        output req_addr,
        output req_wdata,
        output prmgmt_dout,
        input  req_ready,
        input  rsp_valid,
        input  rsp_write,
        input  rsp_rdata,
        input  prmgmt_cmd,
        input  prmgmt_addr,
        input  prmgmt_din
    );
endinterface

// File: rtl/prmgmt_csr_master.sv
// ---------------------------------------------------------------------------
// prmgmt_csr_master
// Initiator on the HSSI PR management bus. Turns one MAC CSR request
// (port, address, read/write) into the indirect E2E register sequence:
// select port (skipped when the port is cached), stage write data, issue the
// command, wait for the MAC CSR to complete, then read back the result.
// Ports:
//   i_prmgmt_ctrl_clk : sole clock
//   i_prmgmt_arst     : asynchronous reset, active-high; aborts any sequence
//   io_bus            : request/response handshake and register-file bus
// Parameters:
//   WAIT_CYCLES : idle cycles after the command write (>=1)
//   RD_LAT      : cycles from prmgmt_addr to valid prmgmt_dout (>=1)
// ---------------------------------------------------------------------------
module prmgmt_csr_master #(
    parameter int unsigned WAIT_CYCLES = 16,
    parameter int unsigned RD_LAT      = 2
) (
    input logic                     i_prmgmt_ctrl_clk,
    input logic                     i_prmgmt_arst,
    prmgmt_csr_master_if.master     io_bus
);

    // One counter serves both WAIT (WAIT_CYCLES-1 .. 0) and RADDR (RD_LAT .. 0).
    localparam int unsigned CNT_MAX = (WAIT_CYCLES - 1 > RD_LAT) ? WAIT_CYCLES - 1 : RD_LAT;
    localparam int unsigned CNT_W   = (CNT_MAX < 1) ? 1 : $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] WAIT_LOAD  = CNT_W'(WAIT_CYCLES - 1);
    localparam logic [CNT_W-1:0] RADDR_LOAD = CNT_W'(RD_LAT);

    localparam logic [15:0] CMD_WR   = 16'h0001;
    localparam logic [15:0] CMD_RD   = 16'h0002;
    localparam logic [15:0] REG_CMD  = 16'h0002;
    localparam logic [15:0] REG_WDAT = 16'h0003;
    localparam logic [15:0] REG_RDAT = 16'h0004;
    localparam logic [15:0] REG_PORT = 16'h0005;

    typedef enum logic [2:0] {
        StIdle,
        StSel,
        StWdata,
        StCmd,
        StWait,
        StRaddr,
        StDone
    } state_e;

    state_e           r_state;
    state_e           w_state_nxt;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    logic             r_write;
    logic [1:0]       r_port;
    logic [15:0]      r_addr;
    logic [31:0]      r_wdata;
    logic             r_cache_vld;
    logic [1:0]       r_cache_port;
    logic [31:0]      r_rdata;

    logic             w_accept;
    logic             w_hit;
    logic             w_cache_set;
    logic             w_capture;
    logic             w_ready;
    logic             w_rsp_valid;
    logic             w_rsp_write;
    logic [15:0]      w_cmd;
    logic [15:0]      w_addr;
    logic [31:0]      w_din;

    assign w_hit    = r_cache_vld && (io_bus.req_port == r_cache_port);
    assign w_accept = w_ready && io_bus.req_valid;

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_ready     = 1'b0;
        w_rsp_valid = 1'b0;
        w_rsp_write = 1'b0;
        w_cache_set = 1'b0;
        w_capture   = 1'b0;
        w_cmd       = 16'h0000;
        w_addr      = 16'h0000;
        w_din       = 32'h0000_0000;
        unique case (r_state)
            StIdle: begin
                w_ready = 1'b1;
                if (io_bus.req_valid) begin
                    if (!w_hit) begin
                        w_state_nxt = StSel;
                    end else if (io_bus.req_write) begin
                        w_state_nxt = StWdata;
                    end else begin
                        w_state_nxt = StCmd;
                    end
                end
            end
            StSel: begin
                w_cmd       = CMD_WR;
                w_addr      = REG_PORT;
                w_din       = {30'b0, r_port};
                w_cache_set = 1'b1;
                w_state_nxt = r_write ? StWdata : StCmd;
            end
            StWdata: begin
                w_cmd       = CMD_WR;
                w_addr      = REG_WDAT;
                w_din       = r_wdata;
                w_state_nxt = StCmd;
            end
            StCmd: begin
                w_cmd       = CMD_WR;
                w_addr      = REG_CMD;
                w_din       = (r_write ? 32'h0001_0000 : 32'h0002_0000) | {16'h0000, r_addr};
                w_cnt_nxt   = WAIT_LOAD;
                w_state_nxt = StWait;
            end
            StWait: begin
                if (r_cnt == '0) begin
                    if (r_write) begin
                        w_state_nxt = StDone;
                    end else begin
                        w_cnt_nxt   = RADDR_LOAD;
                        w_state_nxt = StRaddr;
                    end
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            StRaddr: begin
                w_cmd  = CMD_RD;
                w_addr = REG_RDAT;
                // Read data is valid RD_LAT cycles after the first address cycle.
                if (r_cnt == '0) begin
                    w_capture   = 1'b1;
                    w_state_nxt = StDone;
                end else begin
                    w_cnt_nxt = r_cnt - 1'b1;
                end
            end
            StDone: begin
                w_rsp_valid = 1'b1;
                w_rsp_write = r_write;
                w_state_nxt = StIdle;
            end
            default: begin
                w_state_nxt = StIdle;
            end
        endcase
    end

    always_ff @(posedge i_prmgmt_ctrl_clk or posedge i_prmgmt_arst) begin
        if (i_prmgmt_arst) begin
            r_state      <= StIdle;
            r_cnt        <= '0;
            r_write      <= 1'b0;
            r_port       <= 2'b00;
            r_addr       <= 16'h0000;
            r_wdata      <= 32'h0000_0000;
            r_cache_vld  <= 1'b0;
            r_cache_port <= 2'b00;
            r_rdata      <= 32'h0000_0000;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            if (w_accept) begin
                r_write <= io_bus.req_write;
                r_port  <= io_bus.req_port;
                r_addr  <= io_bus.req_addr;
                r_wdata <= io_bus.req_wdata;
            end
            if (w_cache_set) begin
                r_cache_vld  <= 1'b1;
                r_cache_port <= r_port;
            end
            if (w_capture) begin
                r_rdata <= io_bus.prmgmt_dout;
            end
        end
    end

    assign io_bus.req_ready   = w_ready;
    assign io_bus.rsp_valid   = w_rsp_valid;
    assign io_bus.rsp_write   = w_rsp_write;
    assign io_bus.rsp_rdata   = r_rdata;
    assign io_bus.prmgmt_cmd  = w_cmd;
    assign io_bus.prmgmt_addr = w_addr;
    assign io_bus.prmgmt_din  = w_din;

endmodule

// File: tb/tb_prmgmt_csr_master.sv
// ---------------------------------------------------------------------------
// tb_prmgmt_csr_master
// Self-checking bench: a register-file model answers reads, a per-cycle
// expected-trace queue built from the sequence rules is compared against the
// DUT every cycle, and directed tests pin latencies and bus values with
// literal expectations before a randomized request phase.
// ---------------------------------------------------------------------------
module tb_prmgmt_csr_master;

    localparam int unsigned WAIT_CYCLES = 16;
    localparam int unsigned RD_LAT      = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    prmgmt_csr_master_if bus ();

    prmgmt_csr_master #(
        .WAIT_CYCLES (WAIT_CYCLES),
        .RD_LAT      (RD_LAT)
    ) dut (
        .i_prmgmt_ctrl_clk (clk),
        .i_prmgmt_arst     (rst),
        .io_bus            (bus)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Register file: index 4 returns the current read value, others return junk.
    logic [31:0] reg_rd_val = 32'h0;
    logic [31:0] rd_pipe [RD_LAT];
    always @(posedge clk) begin
        rd_pipe[0] <= (bus.prmgmt_addr == 16'h0004) ? reg_rd_val
                                                    : (32'hBAD0_0000 | {16'h0, bus.prmgmt_addr});
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end
    assign bus.prmgmt_dout = rd_pipe[RD_LAT-1];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // ---------------- behavioural model: expected per-cycle outputs --------
    typedef struct packed {
        logic        rdy;
        logic [15:0] cmd;
        logic [15:0] addr;
        logic [31:0] din;
        logic        rv;
        logic        rw;
        logic [31:0] rdata;
    } exp_t;

    exp_t        exp_q[$];
    bit          m_cvld  = 1'b0;
    logic [1:0]  m_cport = 2'b00;
    logic [31:0] m_rdata = 32'h0;

    function automatic exp_t bus_cyc(logic [15:0] c, logic [15:0] a, logic [31:0] d);
        exp_t e;
        e      = '0;
        e.cmd  = c;
        e.addr = a;
        e.din  = d;
        return e;
    endfunction

    task automatic push_trace(input logic w, input logic [1:0] p, input logic [15:0] a,
                              input logic [31:0] d);
        exp_t e;
        if (!m_cvld || p != m_cport) exp_q.push_back(bus_cyc(16'h1, 16'h5, {30'b0, p}));
        m_cvld  = 1'b1;
        m_cport = p;
        if (w) exp_q.push_back(bus_cyc(16'h1, 16'h3, d));
        exp_q.push_back(bus_cyc(16'h1, 16'h2, (w ? 32'h0001_0000 : 32'h0002_0000) | {16'h0, a}));
        for (int i = 0; i < int'(WAIT_CYCLES); i++) exp_q.push_back(bus_cyc(16'h0, 16'h0, 32'h0));
        if (!w) for (int i = 0; i <= int'(RD_LAT); i++) exp_q.push_back(bus_cyc(16'h2, 16'h4, 32'h0));
        e       = bus_cyc(16'h0, 16'h0, 32'h0);
        e.rv    = 1'b1;
        e.rw    = w;
        e.rdata = reg_rd_val;
        exp_q.push_back(e);
    endtask

    // Compare process: one check of every output per cycle.
    always @(negedge clk) begin
        exp_t e;
        exp_t act;
        if (rst) begin
            exp_q.delete();
            m_cvld  = 1'b0;
            m_rdata = 32'h0;
            e       = '0;
            e.rdy   = 1'b1;
        end else if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
        end else begin
            e     = '0;
            e.rdy = 1'b1;
        end
        if (e.rv && !e.rw) m_rdata = e.rdata;
        e.rdata   = m_rdata;
        act.rdy   = bus.req_ready;
        act.cmd   = bus.prmgmt_cmd;
        act.addr  = bus.prmgmt_addr;
        act.din   = bus.prmgmt_din;
        act.rv    = bus.rsp_valid;
        act.rw    = bus.rsp_write;
        act.rdata = bus.rsp_rdata;
        n_tests++;
        if (act !== e) begin
            n_fail++;
            $display("FAIL bus_cycle %0d: got rdy=%b cmd=%h addr=%h din=%h rv=%b rw=%b rdata=%h, expected rdy=%b cmd=%h addr=%h din=%h rv=%b rw=%b rdata=%h",
                     cyc, act.rdy, act.cmd, act.addr, act.din, act.rv, act.rw, act.rdata,
                     e.rdy, e.cmd, e.addr, e.din, e.rv, e.rw, e.rdata);
        end
        if (!rst && bus.req_valid && bus.req_ready)
            push_trace(bus.req_write, bus.req_port, bus.req_addr, bus.req_wdata);
    end

    // ---------------- stimulus helpers -------------------------------------
    bit         s_cvld  = 1'b0;
    logic [1:0] s_cport = 2'b00;

    task automatic drive_req(input logic w, input logic [1:0] p, input logic [15:0] a,
                             input logic [31:0] d);
        @(posedge clk);
        #1;
        bus.req_valid = 1'b1;
        bus.req_write = w;
        bus.req_port  = p;
        bus.req_addr  = a;
        bus.req_wdata = d;
    endtask

    // Returns accept cycle and the expected accept-to-response latency.
    task automatic wait_accept(output int c0, output int el);
        c0 = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.req_ready === 1'b1) begin
                c0 = cyc;
                break;
            end
        end
        if (c0 < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL accept_timeout: got no req_ready, expected accept within 300 cycles");
        end
        el = int'(WAIT_CYCLES) + 3 + (bus.req_write ? 0 : int'(RD_LAT)) +
             ((!s_cvld || bus.req_port != s_cport) ? 1 : 0);
        s_cvld  = 1'b1;
        s_cport = bus.req_port;
        @(posedge clk);
        #1;
        bus.req_valid = 1'b0;
        bus.req_write = 1'($urandom_range(0, 1));
        bus.req_port  = 2'($urandom_range(0, 3));
        bus.req_addr  = 16'($urandom);
        bus.req_wdata = $urandom;
    endtask

    task automatic start_req(input logic w, input logic [1:0] p, input logic [15:0] a,
                             input logic [31:0] d, output int c0, output int el);
        drive_req(w, p, a, d);
        wait_accept(c0, el);
    endtask

    task automatic wait_rsp(output int r);
        r = -1;
        for (int i = 0; i < 300; i++) begin
            @(negedge clk);
            if (bus.rsp_valid === 1'b1) begin
                r = cyc;
                break;
            end
        end
        if (r < 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL rsp_timeout: got no rsp_valid, expected one within 300 cycles");
        end
    endtask

    task automatic hold_reset();
        rst    = 1'b1;
        s_cvld = 1'b0;
        #1;
        chk("rst_cmd_same_cycle", {16'h0, bus.prmgmt_cmd}, 32'h0);
        chk("rst_ready", {31'h0, bus.req_ready}, 32'h1);
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    // ---------------- test sequence ----------------------------------------
    initial begin
        int c0, el, r, ca, cb, ea, eb;
        bus.req_valid = 1'b0;
        bus.req_write = 1'b0;
        bus.req_port  = 2'b00;
        bus.req_addr  = 16'h0;
        bus.req_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;

        // 1: reset asserted mid-idle, held three clocks
        repeat (2) @(posedge clk);
        #2;
        hold_reset();

        // 2: cold write on port 2
        start_req(1'b1, 2'd2, 16'h0010, 32'hDEADBEEF, c0, el);
        @(negedge clk);
        chk("w_cyc1_addr", {16'h0, bus.prmgmt_addr}, 32'h5);
        chk("w_cyc1_din", bus.prmgmt_din, 32'h2);
        @(negedge clk);
        chk("w_cyc2_addr", {16'h0, bus.prmgmt_addr}, 32'h3);
        chk("w_cyc2_din", bus.prmgmt_din, 32'hDEADBEEF);
        @(negedge clk);
        chk("w_cyc3_din", bus.prmgmt_din, 32'h0001_0010);
        wait_rsp(r);
        chk("w_latency", 32'(r - c0), 32'd20);
        chk("w_rsp_write", {31'h0, bus.rsp_write}, 32'h1);

        // 3: cached read on port 2
        reg_rd_val = 32'h12345678;
        start_req(1'b0, 2'd2, 16'h0010, 32'h0, c0, el);
        @(negedge clk);
        chk("r_cyc1_din", bus.prmgmt_din, 32'h0002_0010);
        wait_rsp(r);
        chk("r_latency", 32'(r - c0), 32'd21);
        chk("r_rdata", bus.rsp_rdata, 32'h12345678);
        chk("r_rsp_write", {31'h0, bus.rsp_write}, 32'h0);

        // 4: read on port 0 re-selects
        reg_rd_val = $urandom;
        start_req(1'b0, 2'd0, 16'h0ABC, 32'h0, c0, el);
        @(negedge clk);
        chk("p0_sel_addr", {16'h0, bus.prmgmt_addr}, 32'h5);
        chk("p0_sel_din", bus.prmgmt_din, 32'h0);
        wait_rsp(r);
        chk("p0_latency", 32'(r - c0), 32'd22);

        // 5: second request held valid during a busy sequence
        start_req(1'b1, 2'd0, 16'h0021, 32'hCAFE_F00D, ca, ea);
        reg_rd_val = 32'hA5A5_0F0F;
        drive_req(1'b0, 2'd3, 16'h0777, 32'h1111_2222);
        wait_rsp(r);
        chk("b2b_a_latency", 32'(r - ca), 32'd19);
        wait_accept(cb, eb);
        chk("b2b_accept_cycle", 32'(cb - r), 32'd1);
        wait_rsp(r);
        chk("b2b_b_latency", 32'(r - cb), 32'd22);
        chk("b2b_b_rdata", bus.rsp_rdata, 32'hA5A5_0F0F);

        // 6: reset during WAIT, then during CMD; cache must be invalidated
        start_req(1'b0, 2'd3, 16'h0042, 32'h0, c0, el);
        repeat (4) @(negedge clk);
        @(posedge clk);
        #1;
        hold_reset();
        reg_rd_val = 32'h0BAD_CAFE;
        start_req(1'b0, 2'd3, 16'h0043, 32'h0, c0, el);
        @(negedge clk);
        chk("rst_resel_addr", {16'h0, bus.prmgmt_addr}, 32'h5);
        @(posedge clk);
        #1;
        chk("cmd_cycle_active", {16'h0, bus.prmgmt_cmd}, 32'h1);
        hold_reset();
        start_req(1'b0, 2'd3, 16'h0044, 32'h0, c0, el);
        wait_rsp(r);
        chk("post_rst_latency", 32'(r - c0), 32'd22);
        chk("post_rst_rdata", bus.rsp_rdata, 32'h0BAD_CAFE);

        // Randomized requests
        for (int n = 0; n < 40; n++) begin
            logic       w;
            logic [1:0] p;
            w = 1'($urandom_range(0, 1));
            p = 2'($urandom_range(0, 3));
            if (!w) reg_rd_val = $urandom;
            repeat ($urandom_range(0, 3)) @(posedge clk);
            start_req(w, p, 16'($urandom), $urandom, c0, el);
            wait_rsp(r);
            chk("rand_latency", 32'(r - c0), 32'(el));
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
